// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Hardwired Moore sequencer for the single-bus datapath. It steps through a
// shared fetch (T0..T2) and then the per-instruction execute micro-steps
// (T3..T7) selected by the opcode in IR[31:27]. Every output is decoded from
// the registered state and the opcode; nothing but the state is stored.
//
// Ports
//   clk         system clock, rising edge
//   clr         asynchronous active-low reset (forces state RST)
//   IR          instruction register, only [31:27] is decoded
//   CON         branch condition flip-flop, gates PC_enable in T6 of br
//   PCout, MDRout, ZLowout, ZHighout, BAout, Cout, R_out
//               bus-source selects (at most one high per state)
//   MAR_enable, MDR_enable, IR_enable, PC_enable, Y_enable,
//   ZLowIn, ZHighIn, R_in, CON_enable
//               register load enables
//   Gra, Grb, Grc
//               register-field selects
//   IncPC       PC increment request to the ALU
//   MDR_read    MDR loads from RAM instead of the bus
//   RAM_write   RAM write strobe
//   opCode      ALU operation (00000 unless ZLowIn is asserted)
//   run         high while executing, low once halted
//   tstate      current state encoding, for debug
// -----------------------------------------------------------------------------
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        PCout,
  output logic        MDRout,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        BAout,
  output logic        Cout,
  output logic        R_out,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        IR_enable,
  output logic        PC_enable,
  output logic        Y_enable,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        R_in,
  output logic        CON_enable,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        MDR_read,
  output logic        RAM_write,
  output logic [4:0]  opCode,
  output logic        run,
  output logic [3:0]  tstate
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd15
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic [4:0] op;
  logic       unused_ir;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg <= S_RST;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    PCout      = 1'b0;
    MDRout     = 1'b0;
    ZLowout    = 1'b0;
    ZHighout   = 1'b0;
    BAout      = 1'b0;
    Cout       = 1'b0;
    R_out      = 1'b0;
    MAR_enable = 1'b0;
    MDR_enable = 1'b0;
    IR_enable  = 1'b0;
    PC_enable  = 1'b0;
    Y_enable   = 1'b0;
    ZLowIn     = 1'b0;
    ZHighIn    = 1'b0;
    R_in       = 1'b0;
    CON_enable = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    IncPC      = 1'b0;
    MDR_read   = 1'b0;
    RAM_write  = 1'b0;
    opCode     = 5'b00000;
    run        = 1'b1;

    case (state_reg)
      S_RST: begin
        state_next = S_T0;
      end

      // Fetch: MAR <- PC, Z <- PC + 1
      S_T0: begin
        PCout      = 1'b1;
        MAR_enable = 1'b1;
        IncPC      = 1'b1;
        ZLowIn     = 1'b1;
        opCode     = OP_ADD;
        state_next = S_T1;
      end

      // PC <- Z, MDR <- RAM[MAR] (synchronous read lands this cycle)
      S_T1: begin
        ZLowout    = 1'b1;
        PC_enable  = 1'b1;
        MDR_read   = 1'b1;
        MDR_enable = 1'b1;
        state_next = S_T2;
      end

      S_T2: begin
        MDRout     = 1'b1;
        IR_enable  = 1'b1;
        state_next = S_T3;
      end

      // First decode step; IR holds the new instruction from here on.
      S_T3: begin
        state_next = S_T0;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            Grb        = 1'b1;
            R_out      = 1'b1;
            Y_enable   = 1'b1;
            state_next = S_T4;
          end
          OP_LD, OP_ST: begin
            Grb        = 1'b1;
            BAout      = 1'b1;
            Y_enable   = 1'b1;
            state_next = S_T4;
          end
          OP_BR: begin
            Gra        = 1'b1;
            R_out      = 1'b1;
            CON_enable = 1'b1;
            state_next = S_T4;
          end
          OP_JR: begin
            Gra       = 1'b1;
            R_out     = 1'b1;
            PC_enable = 1'b1;
          end
          OP_HALT: begin
            state_next = S_HALT;
          end
          default: begin
            // nop and undefined opcodes do nothing for one cycle
          end
        endcase
      end

      S_T4: begin
        state_next = S_T5;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            Grc    = 1'b1;
            R_out  = 1'b1;
            ZLowIn = 1'b1;
            opCode = op;
          end
          OP_ADDI, OP_LD, OP_ST: begin
            Cout   = 1'b1;
            ZLowIn = 1'b1;
            opCode = OP_ADD;
          end
          OP_BR: begin
            PCout    = 1'b1;
            Y_enable = 1'b1;
          end
          default: begin
            state_next = S_T0;
          end
        endcase
      end

      S_T5: begin
        state_next = S_T0;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            ZLowout = 1'b1;
            Gra     = 1'b1;
            R_in    = 1'b1;
          end
          OP_LD, OP_ST: begin
            ZLowout    = 1'b1;
            MAR_enable = 1'b1;
            state_next = S_T6;
          end
          OP_BR: begin
            Cout       = 1'b1;
            ZLowIn     = 1'b1;
            opCode     = OP_ADD;
            state_next = S_T6;
          end
          default: begin
          end
        endcase
      end

      S_T6: begin
        state_next = S_T0;
        case (op)
          OP_LD: begin
            MDR_read   = 1'b1;
            MDR_enable = 1'b1;
            state_next = S_T7;
          end
          OP_ST: begin
            Gra        = 1'b1;
            R_out      = 1'b1;
            MDR_enable = 1'b1;
            state_next = S_T7;
          end
          OP_BR: begin
            // Branch target is taken only when the latched condition holds.
            ZLowout   = 1'b1;
            PC_enable = CON;
          end
          default: begin
          end
        endcase
      end

      S_T7: begin
        state_next = S_T0;
        case (op)
          OP_LD: begin
            MDRout = 1'b1;
            Gra    = 1'b1;
            R_in   = 1'b1;
          end
          OP_ST: begin
            RAM_write = 1'b1;
          end
          default: begin
          end
        endcase
      end

      S_HALT: begin
        run        = 1'b0;
        state_next = S_HALT;
      end

      default: begin
        // Unused encodings fall back to reset.
        run        = 1'b0;
        state_next = S_RST;
      end
    endcase
  end

  assign tstate = state_reg;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clk;
  logic        clr;
  logic [31:0] IR;
  logic        CON;
  logic        PCout, MDRout, ZLowout, ZHighout, BAout, Cout, R_out;
  logic        MAR_enable, MDR_enable, IR_enable, PC_enable, Y_enable;
  logic        ZLowIn, ZHighIn, R_in, CON_enable;
  logic        Gra, Grb, Grc, IncPC, MDR_read, RAM_write;
  logic [4:0]  opCode;
  logic        run;
  logic [3:0]  tstate;

  control_unit dut (
    .clk(clk), .clr(clr), .IR(IR), .CON(CON),
    .PCout(PCout), .MDRout(MDRout), .ZLowout(ZLowout), .ZHighout(ZHighout),
    .BAout(BAout), .Cout(Cout), .R_out(R_out),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .IR_enable(IR_enable),
    .PC_enable(PC_enable), .Y_enable(Y_enable), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .R_in(R_in), .CON_enable(CON_enable),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .IncPC(IncPC), .MDR_read(MDR_read), .RAM_write(RAM_write),
    .opCode(opCode), .run(run), .tstate(tstate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed word: {22 control bits, opCode, run, tstate}
  logic [31:0] obs;
  assign obs = {PCout, MDRout, ZLowout, ZHighout, BAout, Cout, R_out,
                MAR_enable, MDR_enable, IR_enable, PC_enable, Y_enable,
                ZLowIn, ZHighIn, R_in, CON_enable,
                Gra, Grb, Grc, IncPC, MDR_read, RAM_write,
                opCode, run, tstate};

  localparam logic [21:0] C_PCOUT = 22'd1 << 21;
  localparam logic [21:0] C_MDROUT = 22'd1 << 20;
  localparam logic [21:0] C_ZLOUT = 22'd1 << 19;
  localparam logic [21:0] C_BAOUT = 22'd1 << 17;
  localparam logic [21:0] C_COUT = 22'd1 << 16;
  localparam logic [21:0] C_ROUT = 22'd1 << 15;
  localparam logic [21:0] C_MAR = 22'd1 << 14;
  localparam logic [21:0] C_MDREN = 22'd1 << 13;
  localparam logic [21:0] C_IREN = 22'd1 << 12;
  localparam logic [21:0] C_PCEN = 22'd1 << 11;
  localparam logic [21:0] C_YEN = 22'd1 << 10;
  localparam logic [21:0] C_ZLIN = 22'd1 << 9;
  localparam logic [21:0] C_RIN = 22'd1 << 7;
  localparam logic [21:0] C_CONEN = 22'd1 << 6;
  localparam logic [21:0] C_GRA = 22'd1 << 5;
  localparam logic [21:0] C_GRB = 22'd1 << 4;
  localparam logic [21:0] C_GRC = 22'd1 << 3;
  localparam logic [21:0] C_INCPC = 22'd1 << 2;
  localparam logic [21:0] C_MDRRD = 22'd1 << 1;
  localparam logic [21:0] C_RAMWR = 22'd1 << 0;

  localparam logic [4:0] OP_LD = 5'b00000, OP_ST = 5'b00010, OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_BR = 5'b10010, OP_JR = 5'b10011;
  localparam logic [4:0] OP_NOP = 5'b11010, OP_HALT = 5'b11011;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  logic [31:0] seq_q[$];

  function automatic logic [31:0] ev(input logic [21:0] c, input logic [4:0] o,
                                     input logic r, input logic [3:0] t);
    return {c, o, r, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Reference: an instruction is the fetch micro-steps followed by the
  // execute micro-steps listed for its class; tstate is simply 1 + step index.
  task automatic step(input logic [21:0] c, input logic [4:0] o);
    seq_q.push_back(ev(c, o, 1'b1, 4'(seq_q.size() + 1)));
  endtask

  task automatic model(input logic [4:0] opc, input logic con);
    seq_q.delete();
    step(C_PCOUT | C_MAR | C_INCPC | C_ZLIN, OP_ADD);
    step(C_ZLOUT | C_PCEN | C_MDRRD | C_MDREN, 5'd0);
    step(C_MDROUT | C_IREN, 5'd0);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        step(C_GRB | C_ROUT | C_YEN, 5'd0);
        step(C_GRC | C_ROUT | C_ZLIN, opc);
        step(C_ZLOUT | C_GRA | C_RIN, 5'd0);
      end
      OP_ADDI: begin
        step(C_GRB | C_ROUT | C_YEN, 5'd0);
        step(C_COUT | C_ZLIN, OP_ADD);
        step(C_ZLOUT | C_GRA | C_RIN, 5'd0);
      end
      OP_LD, OP_ST: begin
        step(C_GRB | C_BAOUT | C_YEN, 5'd0);
        step(C_COUT | C_ZLIN, OP_ADD);
        step(C_ZLOUT | C_MAR, 5'd0);
        if (opc == OP_LD) begin
          step(C_MDRRD | C_MDREN, 5'd0);
          step(C_MDROUT | C_GRA | C_RIN, 5'd0);
        end else begin
          step(C_GRA | C_ROUT | C_MDREN, 5'd0);
          step(C_RAMWR, 5'd0);
        end
      end
      OP_BR: begin
        step(C_GRA | C_ROUT | C_CONEN, 5'd0);
        step(C_PCOUT | C_YEN, 5'd0);
        step(C_COUT | C_ZLIN, OP_ADD);
        step(C_ZLOUT | (con ? C_PCEN : 22'd0), 5'd0);
      end
      OP_JR: step(C_GRA | C_ROUT | C_PCEN, 5'd0);
      default: step(22'd0, 5'd0);
    endcase
  endtask

  // Issue one instruction; k>0 stops after k cycles (for mid-instruction reset).
  task automatic run_instr(input logic [31:0] ir, input logic con, input int k);
    int n;
    IR = ir;
    CON = con;
    model(ir[31:27], con);
    n = (k > 0 && k < seq_q.size()) ? k : seq_q.size();
    for (int i = 0; i < n; i++) exp_q.push_back(seq_q[i]);
    $display("instr op=%b con=%0d cycles=%0d", ir[31:27], con, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    #1;
    chk("async_reset", obs, ev(22'd0, 5'd0, 1'b1, 4'd0));
    repeat (2) exp_q.push_back(ev(22'd0, 5'd0, 1'b1, 4'd0));
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    exp_q.push_back(ev(22'd0, 5'd0, 1'b1, 4'd0));
    @(posedge clk);
    #1;
    $display("reset done");
  endtask

  function automatic logic [31:0] rnd_ir(input logic [4:0] opc);
    logic [31:0] r;
    r = $urandom;
    return {opc, r[26:0]};
  endfunction

  // Monitor: pops one expected word per cycle and checks bus exclusivity.
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      chk("cycle_word", obs, e);
      total++;
      if (!$onehot0(obs[31:25])) begin
        bad++;
        $display("FAIL bus_onehot cycle=%0d actual=%b required=onehot0", cyc, obs[31:25]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] ops [12];
    logic [4:0] o;
    int len;
    ops = '{OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
            OP_BR, OP_JR, OP_NOP, 5'b11111, 5'b00111};
    clr = 1'b0;
    IR = 32'd0;
    CON = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset in the middle of a load, then a clean add
    run_instr(rnd_ir(OP_LD), 1'b0, 5);
    do_reset();
    run_instr(32'h18000000, 1'b0, 0);
    run_instr(rnd_ir(OP_BR), 1'b0, 0);
    run_instr(rnd_ir(OP_BR), 1'b1, 0);
    run_instr(rnd_ir(OP_ST), 1'b1, 0);
    run_instr(rnd_ir(5'b11111), 1'b0, 0);

    for (int i = 0; i < 80; i++) begin
      o = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) begin
        o = 5'($urandom);
        if (o == OP_HALT) o = OP_NOP;
      end
      if ($urandom_range(0, 9) == 0) begin
        model(o, 1'b0);
        len = seq_q.size();
        run_instr(rnd_ir(o), 1'($urandom), $urandom_range(1, len));
        do_reset();
      end else begin
        run_instr(rnd_ir(o), 1'($urandom), 0);
      end
    end

    // Halt: parked for 20 cycles, then released only by reset
    run_instr(rnd_ir(OP_HALT), 1'b0, 0);
    repeat (20) exp_q.push_back(ev(22'd0, 5'd0, 1'b0, 4'd15));
    repeat (20) @(posedge clk);
    #1;
    do_reset();
    run_instr(rnd_ir(OP_NOP), 1'b0, 0);
    run_instr(rnd_ir(OP_ADDI), 1'b0, 0);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
